// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the MIPS core: owns the PC and runs the request/ack handshake with
// instruction memory. It presents one instruction per execute cycle, then steps the PC to the next-PC.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        stall,
    input  logic [1:0]  nPc_sel,
    input  logic        Branch,
    input  logic        Zero,
    input  logic [31:0] jr_target,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        REQ  = 2'b00,
        EXEC = 2'b01,
        HALT = 2'b10
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        addr_err_reg, addr_err_next;

    logic [31:0] branch_off;
    logic [31:0] jump_target;
    logic [31:0] npc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= REQ;
            pc_reg       <= RESET_PC;
            instr_reg    <= 32'd0;
            addr_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            addr_err_reg <= addr_err_next;
        end
    end

    // Next-PC selection; a taken branch outranks any jump encoding.
    assign pc_plus4    = pc_reg + 32'd4;
    assign branch_off  = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign jump_target = {pc_plus4[31:28], instr_reg[25:0], 2'b00};

    always_comb begin
        npc = pc_plus4;
        if (Branch && Zero) begin
            npc = pc_plus4 + branch_off;
        end else if (nPc_sel == 2'b10) begin
            npc = jr_target;
        end else if (nPc_sel == 2'b01) begin
            npc = jump_target;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        addr_err_next = addr_err_reg;
        case (state_reg)
            REQ: begin
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (!stall) begin
                    // A misaligned target freezes the PC at the faulting instruction.
                    if (npc[1:0] != 2'b00) begin
                        addr_err_next = 1'b1;
                        state_next    = HALT;
                    end else begin
                        pc_next    = npc;
                        state_next = REQ;
                    end
                end
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = HALT;
            end
        endcase
    end

    assign imem_req    = (state_reg == REQ);
    assign instr_valid = (state_reg == EXEC);
    assign imem_addr   = pc_reg;
    assign pc          = pc_reg;
    assign instr       = instr_reg;
    assign addr_err    = addr_err_reg;

endmodule
